tt_sel_sequencer: RTL

- Drives the three chip-level selection control lines (select-reset, select-increment, enable) that choose which user module is connected to the shared pad I/O.
- Accepts a target design address over a valid/ready request port.
- Generates the timed reset/increment pulse train and then asserts enable.
- Sits on the board/host side of the control pads and is used on test and bring-up harnesses alongside the multiplexer top.

---
 rtl/tt_sel_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/tt_sel_sequencer.sv
// tt_sel_sequencer: drives the sel_rst_n / sel_inc / ena pad lines to select a user design by address.
// Optional macro TT_SEL_INCREMENTAL_EN: skip the reset pulse when stepping forward from the current address.
module tt_sel_sequencer #(
   parameter int AW         = 10,
   parameter int HALF_CYC   = 2,
   parameter int RST_CYC    = 4,
   parameter int SETTLE_CYC = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic          req_ena,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] cur_addr,
   output logic          cur_valid,
   output logic          sel_rst_n,
   output logic          sel_inc,
   output logic          ena
);
   localparam int MX = (HALF_CYC > RST_CYC) ? ((HALF_CYC > SETTLE_CYC) ? HALF_CYC : SETTLE_CYC)
                                            : ((RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC);
   localparam int TW = $clog2(MX + 1);
   typedef enum logic [2:0] {IDLE, DIS, RST, INC_H, INC_L, SET, FIN} state_t;
   state_t state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d, lim;
   logic [AW-1:0] n_q, n_d, addr_q, addr_d, cur_addr_q, cur_addr_d;
   logic ena_lat_q, ena_lat_d, last;
   logic sel_rst_n_q, sel_rst_n_d, sel_inc_q, sel_inc_d, ena_q, ena_d;
   logic busy_q, busy_d, done_q, done_d, cur_valid_q, cur_valid_d;
`ifdef TT_SEL_INCREMENTAL_EN
   logic skip_q, skip_d;
`endif
   assign lim  = (state_q == RST) ? TW'(RST_CYC - 1)
               : (state_q == INC_H || state_q == INC_L) ? TW'(HALF_CYC - 1) : TW'(SETTLE_CYC - 1);
   assign last = tmr_q == lim;
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      addr_d    = addr_q;
      ena_lat_d = ena_lat_q;
`ifdef TT_SEL_INCREMENTAL_EN
      skip_d    = skip_q;
`endif
      case (state_q)
         IDLE: if (req_valid) begin
            state_d   = DIS;
            addr_d    = req_addr;
            ena_lat_d = req_ena;
`ifdef TT_SEL_INCREMENTAL_EN
            skip_d    = cur_valid_q && req_addr >= cur_addr_q;
            n_d       = skip_d ? req_addr - cur_addr_q : req_addr;
`else
            n_d       = req_addr;
`endif
         end
`ifdef TT_SEL_INCREMENTAL_EN
         DIS:   if (last) state_d = skip_q ? ((n_q == '0) ? SET : INC_H) : RST;
`else
         DIS:   if (last) state_d = RST;
`endif
         RST:   if (last) state_d = (n_q == '0) ? SET : INC_H;
         INC_H: if (last) state_d = INC_L;
         INC_L: if (last) begin
            n_d     = n_q - 1'b1;
            state_d = (n_q == AW'(1)) ? SET : INC_H;
         end
         SET:   if (last) state_d = FIN;
         default: state_d = IDLE;
      endcase
      tmr_d = (state_d != state_q || state_q == IDLE) ? '0 : tmr_q + 1'b1;
   end
   // Pad lines follow the next state so they change on the same edge as the FSM.
   always_comb begin
      sel_rst_n_d = state_d != RST;
      sel_inc_d   = state_d == INC_H;
      ena_d       = (state_d == DIS) ? 1'b0 : (state_q == FIN) ? ena_lat_q : ena_q;
      cur_valid_d = (state_d == DIS) ? 1'b0 : (state_q == FIN) ? 1'b1 : cur_valid_q;
      cur_addr_d  = (state_q == FIN) ? addr_q : cur_addr_q;
      done_d      = state_q == FIN;
      busy_d      = state_d != IDLE || state_q == FIN;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         n_q         <= '0;
         addr_q      <= '0;
         ena_lat_q   <= 1'b0;
         sel_rst_n_q <= 1'b1;
         sel_inc_q   <= 1'b0;
         ena_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cur_addr_q  <= '0;
         cur_valid_q <= 1'b0;
`ifdef TT_SEL_INCREMENTAL_EN
         skip_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         n_q         <= n_d;
         addr_q      <= addr_d;
         ena_lat_q   <= ena_lat_d;
         sel_rst_n_q <= sel_rst_n_d;
         sel_inc_q   <= sel_inc_d;
         ena_q       <= ena_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cur_addr_q  <= cur_addr_d;
         cur_valid_q <= cur_valid_d;
`ifdef TT_SEL_INCREMENTAL_EN
         skip_q      <= skip_d;
`endif
      end
   end
   assign req_ready = state_q == IDLE;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cur_addr  = cur_addr_q;
   assign cur_valid = cur_valid_q;
   assign sel_rst_n = sel_rst_n_q;
   assign sel_inc   = sel_inc_q;
   assign ena       = ena_q;
endmodule
